// File: rtl/mainfsm_mc_pkg.sv
// Shared encodings for the multicycle main controller: state codes,
// datapath mux selects and instruction-class constants.
package mainfsm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FPUEX    = 4'd10,
        FPUWB    = 4'd11,
        FAULT    = 4'd12
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_FPU = 2'b11;

    // Writeback states always retire; MEMWR retires only on the accept cycle.
    function automatic logic retires(input state_t s, input logic mem_rdy);
        case (s)
            ALUWB, MEMWB, BRANCH, FPUWB: retires = 1'b1;
            MEMWR:                       retires = mem_rdy;
            default:                     retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mainfsm_mc_if.sv
// Decoder-side inputs and datapath control outputs of the main controller.
interface mainfsm_mc_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MemReady;
    logic             FPUDone;
    logic             IRWrite;
    logic             AdrSrc;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             FPUW;
    logic             Branch;
    logic             ALUOp;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             FPUStart;
    logic             Retire;
    logic             Fault;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Op, Funct, MemReady, FPUDone,
        input  IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp,
               ALUSrcA, ALUSrcB, ResultSrc, FPUStart, Retire, Fault, InstrCount
    );

    modport slave (
        input  Op, Funct, MemReady, FPUDone,
        output IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp,
               ALUSrcA, ALUSrcB, ResultSrc, FPUStart, Retire, Fault, InstrCount
    );
endinterface

// File: rtl/mainfsm_wdog.sv
// FPU execute watchdog: 8-bit clear/increment counter with terminal compare.
module mainfsm_wdog #(
    parameter int unsigned LIMIT = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic term
);
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign term = (cnt_q == 8'(LIMIT));
endmodule

// File: rtl/mainfsm_mc.sv
// Multicycle main controller: fetch/decode/execute/writeback sequencing with
// memory wait states, FPU start/done handshake, watchdog fault and retire count.
module mainfsm_mc
    import mainfsm_mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned FPU_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    mainfsm_mc_if.slave  bus
);
    state_t           state_q, state_d;
    logic             fpu_first_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_rdy;
    logic             wd_term;
    logic             retire;

    logic       irwrite, adrsrc, nextpc, regw, memw, fpuw, branch, aluop, fault;
    logic [1:0] srca, srcb, rsrc;

    assign mem_rdy = (MEM_WAIT_EN != 0) ? bus.MemReady : 1'b1;
    assign retire  = retires(state_q, mem_rdy);

    mainfsm_wdog #(
        .LIMIT(FPU_TIMEOUT - 1)
    ) u_wdog (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q != FPUEX),
        .inc  (state_q == FPUEX),
        .term (wd_term)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FETCH;
            fpu_first_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fpu_first_q <= (state_d == FPUEX) && (state_q != FPUEX);
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        irwrite = 1'b0;
        adrsrc  = 1'b0;
        nextpc  = 1'b0;
        regw    = 1'b0;
        memw    = 1'b0;
        fpuw    = 1'b0;
        branch  = 1'b0;
        aluop   = 1'b0;
        fault   = 1'b0;
        srca    = SRCA_REG;
        srcb    = SRCB_REG;
        rsrc    = RES_ALUOUT;

        case (state_q)
            FETCH: begin
                srca    = SRCA_PC;
                srcb    = SRCB_FOUR;
                rsrc    = RES_ALURESULT;
                irwrite = mem_rdy;
                nextpc  = mem_rdy;
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                srca = SRCA_PC;
                srcb = SRCB_FOUR;
                rsrc = RES_ALURESULT;
                case (bus.Op)
                    OP_DP:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = bus.Funct[5] ? FAULT : FPUEX;
                endcase
            end
            EXECUTER: begin
                aluop   = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                aluop   = 1'b1;
                srcb    = SRCB_IMM;
                state_d = ALUWB;
            end
            ALUWB: begin
                regw    = 1'b1;
                rsrc    = RES_ALUOUT;
                state_d = FETCH;
            end
            MEMADR: begin
                srcb    = SRCB_IMM;
                state_d = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWB: begin
                regw    = 1'b1;
                rsrc    = RES_DATA;
                state_d = FETCH;
            end
            MEMWR: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
                if (mem_rdy) state_d = FETCH;
            end
            BRANCH: begin
                branch  = 1'b1;
                rsrc    = RES_ALURESULT;
                srcb    = SRCB_IMM;
                state_d = FETCH;
            end
            FPUEX: begin
                // Done wins over the watchdog when both land in the same cycle.
                if (bus.FPUDone)  state_d = FPUWB;
                else if (wd_term) state_d = FAULT;
            end
            FPUWB: begin
                regw    = 1'b1;
                fpuw    = 1'b1;
                rsrc    = RES_ALUOUT;
                state_d = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign bus.IRWrite    = irwrite;
    assign bus.AdrSrc     = adrsrc;
    assign bus.NextPC     = nextpc;
    assign bus.RegW       = regw;
    assign bus.MemW       = memw;
    assign bus.FPUW       = fpuw;
    assign bus.Branch     = branch;
    assign bus.ALUOp      = aluop;
    assign bus.ALUSrcA    = srca;
    assign bus.ALUSrcB    = srcb;
    assign bus.ResultSrc  = rsrc;
    assign bus.FPUStart   = (state_q == FPUEX) && fpu_first_q;
    assign bus.Retire     = retire;
    assign bus.Fault      = fault;
    assign bus.InstrCount = cnt_q;
endmodule
